// File: rtl/cache_axi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cache_axi_pkg                                         |
// | Purpose  : Shared AXI encodings, line geometry and FSM states    |
// |            for the cache-side AXI4 initiator.                    |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package cache_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_8B     = 3'd3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // A 16-byte line moves as two 8-byte beats; AXI len is beats-1.
    localparam int         LINE_BEATS  = 2;
    localparam logic [7:0] LINE_LEN    = 8'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_WR   = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } cax_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_axi_wdog.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cache_axi_wdog                                        |
// | Purpose  : Bus watchdog. Counts cycles spent waiting on the AXI  |
// |            slave and flags expiry after TIMEOUT_CYCLES cycles    |
// |            without any handshake.                                |
// |            Only compiled when CACHE_AXI_TIMEOUT_EN is defined.   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
`ifdef CACHE_AXI_TIMEOUT_EN
module cache_axi_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    assign o_expired = (r_cnt == CW'(TIMEOUT_CYCLES));

    // Count waiting cycles; any handshake or leaving the bus states restarts it.
    always_ff @(posedge clock) begin
        if (!rst_n || !i_active || i_clear) begin
            r_cnt <= '0;
        end else if (!o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/cache_axi_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cache_axi_master                                      |
// | Purpose  : AXI4 initiator for cache requests. Line refill and    |
// |            writeback as 2-beat INCR bursts, uncached access as   |
// |            1-beat FIXED transfers, one transaction at a time.    |
// | Options  : CACHE_AXI_TIMEOUT_EN adds a bus watchdog that aborts  |
// |            a stalled transaction with resp_err.                  |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module cache_axi_master
    import cache_axi_pkg::*;
#(
    parameter logic [3:0] ID_VAL         = 4'd0,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic         clock,
    input  logic         rst_n,
    // cache request side
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic         i_req_we,
    input  logic         i_req_uncached,
    input  logic [31:0]  i_req_addr,
    input  logic [2:0]   i_req_size,
    input  logic [127:0] i_req_wdata,
    input  logic [7:0]   i_req_wstrb,
    output logic         o_resp_valid,
    output logic [127:0] o_resp_rdata,
    output logic         o_resp_err,
    // AXI read address
    output logic [31:0]  o_araddr,
    output logic [3:0]   o_arid,
    output logic [7:0]   o_arlen,
    output logic [2:0]   o_arsize,
    output logic [1:0]   o_arburst,
    output logic         o_arvalid,
    input  logic         i_arready,
    // AXI read data
    input  logic [63:0]  i_rdata,
    input  logic [1:0]   i_rresp,
    input  logic [3:0]   i_rid,
    input  logic         i_rlast,
    input  logic         i_rvalid,
    output logic         o_rready,
    // AXI write address
    output logic [31:0]  o_awaddr,
    output logic [3:0]   o_awid,
    output logic [7:0]   o_awlen,
    output logic [2:0]   o_awsize,
    output logic [1:0]   o_awburst,
    output logic         o_awvalid,
    input  logic         i_awready,
    // AXI write data
    output logic [63:0]  o_wdata,
    output logic [7:0]   o_wstrb,
    output logic         o_wlast,
    output logic         o_wvalid,
    input  logic         i_wready,
    // AXI write response
    input  logic [1:0]   i_bresp,
    input  logic [3:0]   i_bid,
    input  logic         i_bvalid,
    output logic         o_bready
);

    cax_state_t r_state;
    cax_state_t w_state_nxt;

    logic [31:0]  r_addr;
    logic [7:0]   r_len;
    logic [2:0]   r_size;
    logic [1:0]   r_burst;
    logic [127:0] r_wdata;
    logic [7:0]   r_wstrb;
    logic [127:0] r_rdata;
    logic         r_err;
    logic         r_cnt;
    logic         r_aw_done;
    logic         r_w_done;

    logic w_cnt_last;
    logic w_timeout;
    logic w_ar_hs;
    logic w_r_beat;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_beat;

    assign w_cnt_last = ({7'd0, r_cnt} == r_len);
    assign w_ar_hs    = o_arvalid & i_arready;
    // Responses carrying a foreign ID are not ours and are skipped.
    assign w_r_beat   = o_rready & i_rvalid & (i_rid == ID_VAL);
    assign w_aw_hs    = o_awvalid & i_awready;
    assign w_w_hs     = o_wvalid & i_wready;
    assign w_b_beat   = o_bready & i_bvalid & (i_bid == ID_VAL);

`ifdef CACHE_AXI_TIMEOUT_EN
    logic w_wd_active;
    logic w_wd_clear;

    assign w_wd_active = (r_state == ST_AR) || (r_state == ST_R) ||
                         (r_state == ST_WR) || (r_state == ST_B);
    assign w_wd_clear  = w_ar_hs | (o_rready & i_rvalid) | w_aw_hs | w_w_hs |
                         (o_bready & i_bvalid);

    cache_axi_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clock     (clock),
        .rst_n     (rst_n),
        .i_active  (w_wd_active),
        .i_clear   (w_wd_clear),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    assign o_araddr     = r_addr;
    assign o_arid       = ID_VAL;
    assign o_arlen      = r_len;
    assign o_arsize     = r_size;
    assign o_arburst    = r_burst;
    assign o_awaddr     = r_addr;
    assign o_awid       = ID_VAL;
    assign o_awlen      = r_len;
    assign o_awsize     = r_size;
    assign o_awburst    = r_burst;
    assign o_wdata      = r_cnt ? r_wdata[127:64] : r_wdata[63:0];
    assign o_wstrb      = r_wstrb;
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = (r_state == ST_DONE) & r_err;

    // State register.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs; all outputs depend only on registered state.
    always_comb begin
        w_state_nxt  = r_state;
        o_req_ready  = 1'b0;
        o_arvalid    = 1'b0;
        o_rready     = 1'b0;
        o_awvalid    = 1'b0;
        o_wvalid     = 1'b0;
        o_wlast      = 1'b0;
        o_bready     = 1'b0;
        o_resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_state_nxt = i_req_we ? ST_WR : ST_AR;
                end
            end
            ST_AR: begin
                o_arvalid = ~w_timeout;
                if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end else if (i_arready) begin
                    w_state_nxt = ST_R;
                end
            end
            ST_R: begin
                o_rready = ~w_timeout;
                if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end else if (i_rvalid && (i_rid == ID_VAL) && w_cnt_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_WR: begin
                o_awvalid = ~r_aw_done & ~w_timeout;
                o_wvalid  = ~r_w_done & ~w_timeout;
                o_wlast   = w_cnt_last;
                if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end else if ((r_aw_done || i_awready) &&
                             (r_w_done || (i_wready && w_cnt_last))) begin
                    w_state_nxt = ST_B;
                end
            end
            ST_B: begin
                o_bready = ~w_timeout;
                if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end else if (i_bvalid && (i_bid == ID_VAL)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_resp_valid = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture, beat counting, read-data assembly and error accumulation.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_cnt     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_addr    <= i_req_uncached ? i_req_addr : {i_req_addr[31:4], 4'h0};
                        r_len     <= i_req_uncached ? 8'd0 : LINE_LEN;
                        r_size    <= i_req_uncached ? i_req_size : SIZE_8B;
                        r_burst   <= i_req_uncached ? BURST_FIXED : BURST_INCR;
                        r_wstrb   <= i_req_uncached ? i_req_wstrb : 8'hFF;
                        r_wdata   <= i_req_wdata;
                        r_rdata   <= '0;
                        r_err     <= 1'b0;
                        r_cnt     <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                ST_R: begin
                    if (w_r_beat) begin
                        if (r_cnt) begin
                            r_rdata[127:64] <= i_rdata;
                        end else begin
                            r_rdata[63:0] <= i_rdata;
                        end
                        if ((i_rresp == RESP_DECERR) || (i_rlast != w_cnt_last)) begin
                            r_err <= 1'b1;
                        end
                        if (!w_cnt_last) begin
                            r_cnt <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        if (w_cnt_last) begin
                            r_w_done <= 1'b1;
                        end else begin
                            r_cnt <= 1'b1;
                        end
                    end
                end
                ST_B: begin
                    if (w_b_beat && (i_bresp == RESP_DECERR)) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
